// File: rtl/result_writeback.sv
`default_nettype none
// result_writeback: round-robin arbitration of functional-unit results into a
// single write stage that drives the register file and ROB, plus the preg ready scoreboard.
module result_writeback #(
  parameter int UNITS = 4,
  parameter int PREGS = 128,
  parameter int AW    = 7,
  parameter int ROBW  = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [UNITS-1:0]               result_valid,
  output logic [UNITS-1:0]               result_ready,
  input  logic [UNITS-1:0][AW+ROBW+32:0] result_data,
  input  logic                           alloc_valid,
  input  logic [AW-1:0]                  alloc_addr,
  output logic                           wr_en,
  output logic [AW-1:0]                  wr_addr,
  output logic [31:0]                    wr_data,
  output logic                           complete_valid,
  output logic [ROBW-1:0]                complete_rob_id,
  output logic [PREGS-1:0]               register_valid
);

  // Packet layout, MSB first: {has_dest, dest, value, rob_id}
  localparam int RW       = AW + ROBW + 33;
  localparam int PW       = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int VAL_LSB  = ROBW;
  localparam int DEST_LSB = ROBW + 32;
  localparam int HD_BIT   = ROBW + 32 + AW;

  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    cand;
  logic             grant_found;
  logic             transfer;
  logic [RW-1:0]    grant_pkt;
  logic [AW-1:0]    grant_dest;

  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [31:0]      wr_data_q;
  logic             complete_valid_q;
  logic [ROBW-1:0]  rob_id_q;
  logic [PREGS-1:0] sb_q;
  logic [PREGS-1:0] sb_next;

  // First valid unit at or after the pointer, wrapping modulo UNITS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < UNITS; i++) begin
      cand = PW'((int'(ptr_q) + i) % UNITS);
      if (!grant_found && result_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign transfer   = grant_found & ~reset;
  assign grant_pkt  = result_data[grant_idx];
  assign grant_dest = grant_pkt[DEST_LSB +: AW];

  always_comb begin
    result_ready = '0;
    if (transfer) begin
      result_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (transfer) begin
      ptr_q <= (grant_idx == PW'(UNITS - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      complete_valid_q <= 1'b0;
      rob_id_q         <= '0;
    end else begin
      wr_en_q          <= transfer & grant_pkt[HD_BIT] & (grant_dest != '0);
      complete_valid_q <= transfer;
      if (transfer) begin
        wr_addr_q <= grant_dest;
        wr_data_q <= grant_pkt[VAL_LSB +: 32];
        rob_id_q  <= grant_pkt[ROBW-1:0];
      end
    end
  end

  // Set lands on the same edge the register file latches the data; clear wins.
  always_comb begin
    sb_next = sb_q;
    if (wr_en_q) begin
      sb_next[wr_addr_q] = 1'b1;
    end
    if (alloc_valid) begin
      sb_next[alloc_addr] = 1'b0;
    end
    sb_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '1;
    end else begin
      sb_q <= sb_next;
    end
  end

  assign wr_en           = wr_en_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign complete_valid  = complete_valid_q;
  assign complete_rob_id = rob_id_q;
  assign register_valid  = sb_q;

endmodule
`default_nettype wire

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Collects RESULT packets from UNITS functional units over their valid/ready result interface.
- Each cycle, grants one unit by round-robin arbitration and registers the granted result into a single write stage.
- The write stage drives the physical register file write port and a completion report to the ROB.
- Owns the 128-bit register_valid scoreboard that schedulers use to wake operands.

Parameters:
- UNITS, 4, number of functional-unit result inputs (2..8).
- PREGS, 128, number of physical registers; scoreboard width.
- AW, 7, physical register address width (log2 PREGS).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- result_valid  input  UNITS  per-unit result valid.
- result_ready  output  UNITS  per-unit accept; one-hot or zero.
- result_data  input  UNITS x RESULT  per-unit result. Fields used: has_dest (1), dest (AW), value (32), rob_id.
- alloc_valid  input  1  rename allocates a new physical destination this cycle.
- alloc_addr  input  AW  physical register being allocated.
- wr_en  output  1  register file write enable.
- wr_addr  output  AW  register file write address.
- wr_data  output  32  register file write data.
- complete_valid  output  1  ROB completion strobe.
- complete_rob_id  output  ROB id width  ROB entry being completed.
- register_valid  output  PREGS  scoreboard; bit i = 1 means preg i holds final data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state is updated only on the rising edge of clk.
- Reset values:
  - wr_en = 0, complete_valid = 0, wr_addr/wr_data/complete_rob_id = 0.
  - register_valid = all ones.
  - Round-robin pointer = 0 (unit 0 has highest priority first).
  - result_ready = 0 during reset.
- Arbitration (combinational):
  - Among asserted result_valid bits, grant the first unit at or after the pointer, with wrap-around modulo UNITS.
  - result_ready is one-hot on the granted unit. A transfer occurs when result_valid & result_ready.
  - No valid inputs: result_ready = 0 and the pointer holds.
  - The write stage never stalls, so a grant is issued every cycle any input is valid.
- Pointer update: after a transfer from unit g, the pointer becomes (g+1) mod UNITS. Result: a continuously valid unit is granted at least once every UNITS cycles.
- Write stage (1-cycle latency): a transfer in cycle N registers the packet; in cycle N+1 the stage drives:
  - wr_en = has_dest & (dest != 0), wr_addr = dest, wr_data = value.
  - complete_valid = 1, complete_rob_id = rob_id.
  - has_dest = 0 results (branches, stores): complete only, wr_en = 0.
  - No transfer in N: wr_en = 0 and complete_valid = 0 in N+1.
- Scoreboard:
  - Set: bit dest is set at the end of cycle N+1, i.e. the same edge the register file latches the write. The bit therefore reads 1 from cycle N+2, so a woken scheduler's read sees the new data.
  - Clear: alloc_valid clears bit alloc_addr at the end of the cycle it is asserted.
  - Same-cycle set and clear of the same bit: clear wins.
  - Bit 0 (preg 0, zero register) is never cleared and always reads 1. An alloc_addr of 0 is ignored.
  - Sets and clears to different bits in the same cycle both take effect.
- Reset mid-operation: a registered write-stage packet is discarded (no wr_en or complete_valid the next cycle), the scoreboard returns to all ones, and pending inputs are not granted while reset is high.
- X-safety: result_data is ignored when result_valid is 0. wr_addr/wr_data are don't-care when wr_en is 0, but must not be X after reset.

Test Plan:
- Single result: unit 1 presents dest=5, value=0xDEADBEEF, rob_id=3, has_dest=1 at cycle 10.
  -> result_ready=4'b0010 in cycle 10.
  -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, complete_valid=1, complete_rob_id=3 in cycle 11.
  -> register_valid[5] reads 1 from cycle 12.
- Round-robin fairness: all 4 units valid continuously for 8 cycles from reset.
  -> grant order 0,1,2,3,0,1,2,3; exactly 8 completions, one per cycle.
- Alloc then writeback:
  - alloc_valid=1, alloc_addr=40 in cycle 5 -> register_valid[40]=0 from cycle 6.
  - A result to dest 40 granted in cycle 8 -> bit 40 reads 1 from cycle 10.
- Collision: alloc_addr=40 in the same cycle as the write stage sets bit 40 -> bit 40 reads 0 the next cycle.
- No-dest and zero-register results:
  - has_dest=0, rob_id=7 -> complete_valid=1, rob_id=7, wr_en=0.
  - dest=0 result -> wr_en=0.
  - alloc_addr=0 -> register_valid[0] stays 1.
- Reset mid-flight: assert reset in the cycle after a grant.
  -> wr_en=0 and complete_valid=0 the following cycle.
  -> register_valid = all ones.
  -> pointer restarts at unit 0: with units 2 and 0 both valid, unit 0 is granted first.
